// File: rtl/zip_rgb_rx.sv
// zip_rgb_rx: pin-level VGA receiver rebuilding the 26-bit strRGB stream.
// Optional macro RGB_RX_STATS_EN adds a saturating err_cnt output.
module zip_rgb_rx #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int LOCK_FRAMES = 2,
    parameter bit SYNC_ACT    = 1'b0
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        hsync,
    input  logic        Red,
    input  logic        Green,
    input  logic        Blue,
    output logic [25:0] strRGB,
    output logic        locked,
`ifdef RGB_RX_STATS_EN
    output logic [7:0]  err_cnt,
`endif
    output logic        sync_err
);

    typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

    localparam logic [4:0]  SYNC_RST = {~SYNC_ACT, ~SYNC_ACT, 3'b000};
    localparam logic [9:0]  HS = 10'(H_START);
    localparam logic [9:0]  HE = 10'(H_START + H_VISIBLE);
    localparam logic [9:0]  VS = 10'(V_START);
    localparam logic [9:0]  VE = 10'(V_START + V_VISIBLE);
    localparam logic [10:0] HT = 11'(H_TOTAL);
    localparam logic [10:0] VT = 11'(V_TOTAL);
    localparam logic [3:0]  LF = 4'(LOCK_FRAMES);
    localparam logic [9:0]  SAT = 10'h3FF;

    state_t      state, state_nx;
    logic [3:0]  gcnt, gcnt_nx;
    logic [4:0]  s1, s2;
    logic        hs_d, vs_d;
    logic        hs, vs, hs_edge, vs_edge;
    logic [9:0]  hcnt_q, vcnt_q, hcnt_nx, vcnt_nx;
    logic        line_bad, frame_bad, hsat, vis, av;

    // {vsync, hsync, Red, Green, Blue} through a two-flop synchronizer
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            s1   <= SYNC_RST;
            s2   <= SYNC_RST;
            hs_d <= ~SYNC_ACT;
            vs_d <= ~SYNC_ACT;
        end else begin
            s1   <= {vsync, hsync, Red, Green, Blue};
            s2   <= s1;
            hs_d <= s2[3];
            vs_d <= s2[4];
        end
    end

    assign vs      = s2[4];
    assign hs      = s2[3];
    assign hs_edge = (hs == SYNC_ACT) && (hs_d != SYNC_ACT);
    assign vs_edge = (vs == SYNC_ACT) && (vs_d != SYNC_ACT);

    // Counts for the sample now in s2, so strRGB stays aligned at 3 cycles
    always_comb begin
        hcnt_nx = hcnt_q;
        vcnt_nx = vcnt_q;
        if (hs_edge)
            hcnt_nx = '0;
        else if (hcnt_q != SAT)
            hcnt_nx = hcnt_q + 10'd1;
        if (vs_edge)
            vcnt_nx = '0;
        else if (hs_edge && vcnt_q != SAT)
            vcnt_nx = vcnt_q + 10'd1;
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_nx;
            vcnt_q <= vcnt_nx;
        end
    end

    assign line_bad  = hs_edge && ({1'b0, hcnt_q} + 11'd1 != HT);
    assign frame_bad = vs_edge && ({1'b0, vcnt_q} + 11'd1 != VT);
    assign hsat      = (hcnt_nx == SAT);

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state <= S_SEARCH;
            gcnt  <= '0;
        end else begin
            state <= state_nx;
            gcnt  <= gcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gcnt_nx  = gcnt;
        unique case (state)
            S_SEARCH: begin
                if (vs_edge) begin
                    state_nx = S_MEASURE;
                    gcnt_nx  = '0;
                end
            end
            S_MEASURE: begin
                if (line_bad || frame_bad || hsat) begin
                    state_nx = S_SEARCH;
                end else if (vs_edge) begin
                    gcnt_nx = gcnt + 4'd1;
                    if (gcnt + 4'd1 == LF)
                        state_nx = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (line_bad || frame_bad || hsat)
                    state_nx = S_SEARCH;
            end
            default: state_nx = S_SEARCH;
        endcase
    end

    always_comb begin
        locked   = (state == S_LOCKED);
        sync_err = 1'b0;
        if (state == S_MEASURE)
            sync_err = line_bad || frame_bad;
        else if (state == S_LOCKED)
            sync_err = line_bad || frame_bad || hsat;
    end

    assign vis = (hcnt_nx >= HS) && (hcnt_nx < HE) &&
                 (vcnt_nx >= VS) && (vcnt_nx < VE);
    assign av  = locked && vis;

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            strRGB <= '0;
        end else begin
            strRGB <= {s2[2] & av, s2[1] & av, s2[0] & av, av, vs, hs,
                       av ? vcnt_nx - VS : 10'd0,
                       av ? hcnt_nx - HS : 10'd0};
        end
    end

`ifdef RGB_RX_STATS_EN
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset)
            err_cnt <= '0;
        else if (sync_err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_zip_rgb_rx.sv
// tb_zip_rgb_rx: directed bench for zip_rgb_rx on a reduced 36x32 raster.
// Expected {locked, strRGB} per pin sample is queued and popped 3 cycles later.
module tb_zip_rgb_rx;

    logic        px_clk = 1'b0;
    logic        reset = 1'b0;
    logic        vsync = 1'b1;
    logic        hsync = 1'b1;
    logic        Red = 1'b0;
    logic        Green = 1'b0;
    logic        Blue = 1'b0;
    logic [25:0] strRGB;
    logic        locked;
    logic        sync_err;
`ifdef RGB_RX_STATS_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int err_hi = 0;
    int err_rise = 0;
    int red_hi = 0;
    logic err_prev = 1'b0;
    logic exp_lock = 1'b0;
    logic [26:0] sbq[$];

    zip_rgb_rx #(
        .H_TOTAL(36), .V_TOTAL(32), .H_START(12), .V_START(4),
        .H_VISIBLE(16), .V_VISIBLE(24), .LOCK_FRAMES(2), .SYNC_ACT(1'b0)
    ) dut (
        .px_clk(px_clk),
        .reset(reset),
        .vsync(vsync),
        .hsync(hsync),
        .Red(Red),
        .Green(Green),
        .Blue(Blue),
        .strRGB(strRGB),
        .locked(locked),
`ifdef RGB_RX_STATS_EN
        .err_cnt(err_cnt),
`endif
        .sync_err(sync_err)
    );

    always #5 px_clk = ~px_clk;

    always @(negedge px_clk) begin
        if (sync_err) begin
            err_hi++;
            if (!err_prev) err_rise++;
        end
        err_prev = sync_err;
        if (strRGB[25]) red_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: check the sample driven 3 calls ago, drive a new one.
    task automatic px(input logic h, input logic v, input logic r, input logic g,
                      input logic b, input logic [25:0] e, input logic lk);
        logic [26:0] ex;
        if (sbq.size() == 3) begin
            ex = sbq.pop_front();
            chk("pixel", {5'd0, locked, strRGB}, {5'd0, ex});
        end
        hsync = h; vsync = v; Red = r; Green = g; Blue = b;
        sbq.push_back({lk, e});
        @(negedge px_clk);
    endtask

    // Sync pins idle; base = hcnt of the first sample when lock may drop.
    task automatic hold(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            if (base > 0 && base + i >= 1023) exp_lock = 1'b0;
            px(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {6'b000011, 20'd0}, exp_lock);
        end
    endtask

    task automatic frame(input logic lk, input int short_ln, input int stop_at,
                         input bit color);
        int n;
        int len;
        logic h, v, r, g, b, vis, av;
        logic [9:0] xx, yy;
        n = 0;
        for (int ln = 0; ln < 32; ln++) begin
            len = (ln == short_ln) ? 35 : 36;
            for (int c = 0; c < len; c++) begin
                if (stop_at >= 0 && n == stop_at) return;
                n++;
                if (ln == 0 && c == 0) exp_lock = lk;
                if (short_ln >= 0 && ln == short_ln + 1 && c == 0) exp_lock = 1'b0;
                h = (c < 6) ? 1'b0 : 1'b1;
                v = (ln < 2) ? 1'b0 : 1'b1;
                r = color && ((ln == 24 && c == 22) || (ln == 3 && c == 15));
                g = color && (ln == 4 && c == 12);
                b = color && ((ln == 27 && c == 27) || (ln == 24 && c == 11));
                vis = (c >= 12) && (c < 28) && (ln >= 4) && (ln < 28);
                av = exp_lock && vis;
                xx = av ? 10'(c - 12) : 10'd0;
                yy = av ? 10'(ln - 4) : 10'd0;
                px(h, v, r, g, b, {r & av, g & av, b & av, av, v, h, yy, xx}, exp_lock);
            end
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_strRGB", {6'd0, strRGB}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
        repeat (3) @(negedge px_clk);
        reset = 1'b0;
        hold(20, 0);

        // lock on the 3rd vsync edge, with coincident hsync edges
        frame(1'b0, -1, -1, 1'b0);
        frame(1'b0, -1, -1, 1'b0);
        frame(1'b1, -1, -1, 1'b0);
        frame(1'b1, -1, -1, 1'b0);
        #1;
        chk("t1_no_err", err_rise, 0);
        chk("t1_locked", {31'd0, locked}, 32'd1);

        // pixel placement, including edge pixels and non-visible colour
        frame(1'b1, -1, -1, 1'b1);
        #1;
        chk("t2_red_count", red_hi, 1);

        // short line then relock
        frame(1'b1, 10, -1, 1'b0);
        frame(1'b0, -1, -1, 1'b0);
        frame(1'b0, -1, -1, 1'b0);
        frame(1'b1, -1, -1, 1'b0);
        #1;
        chk("t3_err_pulses", err_rise, 1);
        chk("t3_err_width", err_hi, 1);
        chk("t3_relocked", {31'd0, locked}, 32'd1);

        // hsync lost until hcnt saturates
        frame(1'b1, -1, 6 * 36, 1'b0);
        hold(1100, 36);
        #1;
        chk("t4_err_pulses", err_rise, 2);
        chk("t4_err_width", err_hi, 2);
        chk("t4_unlocked", {31'd0, locked}, 32'd0);

        // reset mid-line while locked
        frame(1'b0, -1, -1, 1'b0);
        frame(1'b0, -1, -1, 1'b0);
        frame(1'b1, -1, -1, 1'b0);
        frame(1'b1, -1, 6 * 36 + 20, 1'b0);
        chk("t6_pre_locked", {31'd0, locked}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_strRGB", {6'd0, strRGB}, 32'd0);
        chk("t6_rst_locked", {31'd0, locked}, 32'd0);
        hsync = 1'b1; vsync = 1'b1; Red = 1'b0; Green = 1'b0; Blue = 1'b0;
        repeat (3) @(negedge px_clk);
        sbq.delete();
        exp_lock = 1'b0;
        reset = 1'b0;
        frame(1'b0, -1, -1, 1'b0);
        frame(1'b0, -1, -1, 1'b0);
        frame(1'b1, -1, -1, 1'b0);
        hold(3, 36);
        #1;
        chk("t6_relocked", {31'd0, locked}, 32'd1);
        chk("t6_err_pulses", err_rise, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
